// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Frame states, parity modes and the parity bit function.
package uart_pkg;

  localparam int MAX_DLEN = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } tx_state_e;

  function automatic logic parity_bit(
    input logic [MAX_DLEN-1:0] data,
    input parity_e             mode
  );
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinct.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wp_q;
  logic [AW:0]      rp_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rp_q[AW-1:0]];
  assign level_o = wp_q - rp_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO, runtime divisor,
// optional parity, 1/2 stop bits and break generation.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DLEN      = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4,
  parameter int DIVW      = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     o_txs,
  input  logic                     i_wvalid,
  output logic                     o_wready,
  input  logic [DLEN-1:0]          i_wdata,
  input  logic [DIVW-1:0]          i_baud_div,
  input  logic                     i_break,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int             BW        = $clog2(DLEN);
  localparam parity_e        PMODE     = parity_e'(PARITY);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DLEN - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  tx_state_e       state_q, state_d;
  logic            txs_q, txs_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] tmr_q, tmr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            stop_q, stop_d;
  logic            brk_q, brk_d;
  logic            par_q, par_d;
  logic [DLEN-1:0] shift_q, shift_d;

  logic            tick, load, done;
  logic            push, full, empty;
  logic [DLEN-1:0] rdata;
  logic [DIVW-1:0] div_eff;

  assign o_wready = rstn && !full;
  assign push     = i_wvalid && o_wready;
  assign div_eff  = (i_baud_div < DIVW'(2)) ? DIVW'(2) : i_baud_div;
  assign tick     = (tmr_q == div_q - 1'b1);

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DLEN)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (i_wdata),
    .pop_i   (load),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (o_level)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      txs_q   <= 1'b1;
      div_q   <= DIVW'(2);
      tmr_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      brk_q   <= 1'b0;
      par_q   <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      txs_q   <= txs_d;
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      brk_q   <= brk_d;
      par_q   <= par_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txs_d   = txs_q;
    div_d   = div_q;
    tmr_d   = tick ? '0 : tmr_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    brk_d   = brk_q;
    par_d   = par_q;
    shift_d = shift_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        txs_d = 1'b1;
        if (i_break) begin
          state_d = S_BREAK;
          txs_d   = 1'b0;
          div_d   = div_eff;
        end else if (!empty) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          txs_d   = shift_q[0];
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txs_d   = par_q;
            end else begin
              state_d = S_STOP;
              txs_d   = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txs_d   = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          txs_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            done  = !brk_q;
            brk_d = 1'b0;
            // Back-to-back frames skip IDLE; a pending break defers to IDLE.
            if (!brk_q && !empty && !i_break) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              txs_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        txs_d = 1'b0;
        if (tick && !i_break) begin
          state_d = S_STOP;
          txs_d   = 1'b1;
          stop_d  = 1'b0;
          brk_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txs_d   = 1'b1;
      end
    endcase
    if (load) begin
      state_d = S_START;
      txs_d   = 1'b0;
      div_d   = div_eff;
      tmr_d   = '0;
      shift_d = rdata;
      par_d   = parity_bit(MAX_DLEN'(rdata), PMODE);
    end
  end

  assign o_txs  = txs_q;
  assign o_done = done;
  assign o_busy = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: 8N1, 8E2 and 8O1 instances,
// frame scoreboards checked cycle by cycle on the serial line.
module tb_uart_tx_fifo;

  typedef struct {
    bit         brk;
    logic [7:0] data;
    int         div;
    int         par;
    int         stops;
  } item_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] wdata;
  logic [15:0] baud;
  logic       wv0, wv1, wv2;
  logic       brk0, brk1, brk2;
  logic       tx [3];
  logic       wr [3];
  logic       busy [3];
  logic       done [3];
  logic [2:0] lvl [3];

  item_t sb0[$], sb1[$], sb2[$];
  int    n_assert = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    last_done_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done[0]) begin
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
  end

  uart_tx_fifo #(
    .DLEN(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4), .DIVW(16)
  ) u0 (
    .clk(clk), .rstn(rstn), .o_txs(tx[0]), .i_wvalid(wv0),
    .o_wready(wr[0]), .i_wdata(wdata), .i_baud_div(baud),
    .i_break(brk0), .o_busy(busy[0]), .o_done(done[0]),
    .o_level(lvl[0])
  );

  uart_tx_fifo #(
    .DLEN(8), .PARITY(2), .STOP_BITS(2), .DEPTH(4), .DIVW(16)
  ) u1 (
    .clk(clk), .rstn(rstn), .o_txs(tx[1]), .i_wvalid(wv1),
    .o_wready(wr[1]), .i_wdata(wdata), .i_baud_div(baud),
    .i_break(brk1), .o_busy(busy[1]), .o_done(done[1]),
    .o_level(lvl[1])
  );

  uart_tx_fifo #(
    .DLEN(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4), .DIVW(16)
  ) u2 (
    .clk(clk), .rstn(rstn), .o_txs(tx[2]), .i_wvalid(wv2),
    .o_wready(wr[2]), .i_wdata(wdata), .i_baud_div(baud),
    .i_break(brk2), .o_busy(busy[2]), .o_done(done[2]),
    .o_level(lvl[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qpush(input int id, input item_t it);
    case (id)
      0: sb0.push_back(it);
      1: sb1.push_back(it);
      default: sb2.push_back(it);
    endcase
  endtask

  task automatic mon(input int id);
    item_t e;
    logic  prev, p;
    logic  bits [16];
    int    nb, sz;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      p = tx[id];
      if (!(mon_en && rstn)) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !p) begin
        sz = (id == 0) ? sb0.size() : (id == 1) ? sb1.size() : sb2.size();
        chk($sformatf("start%0d_expected", id), sz > 0, 1);
        if (sz > 0) begin
          case (id)
            0: e = sb0.pop_front();
            1: e = sb1.pop_front();
            default: e = sb2.pop_front();
          endcase
          bits[0] = 1'b0;
          nb = 1;
          if (!e.brk) begin
            for (int i = 0; i < 8; i++) begin
              bits[nb] = e.data[i];
              nb++;
            end
            if (e.par != 0) begin
              bits[nb] = (e.par == 2) ? ($countones(e.data) % 2 == 1)
                                      : ($countones(e.data) % 2 == 0);
              nb++;
            end
          end
          for (int i = 0; i < e.stops; i++) begin
            bits[nb] = 1'b1;
            nb++;
          end
          for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < e.div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              chk($sformatf("tx%0d_d%02h_bit%0d", id, e.data, b),
                  tx[id], bits[b]);
              chk($sformatf("done%0d_d%02h_bit%0d", id, e.data, b),
                  done[id], !e.brk && b == nb - 1 && c == e.div - 1);
            end
          end
          p = tx[id];
        end
      end else begin
        chk($sformatf("done%0d_idle", id), done[id], 0);
      end
      prev = p;
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic wr0(input logic [7:0] d, input int dv, input bit track);
    int t;
    t = 0;
    wdata = d;
    wv0 = 1'b1;
    while (wr[0] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("wr0_accept", t < 2000, 1);
    if (track) qpush(0, item_t'{1'b0, d, dv, 0, 1});
    @(posedge clk);
    #1 wv0 = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int t;
    t = 0;
    @(negedge clk);
    while (busy[id] !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("idle%0d_reached", id), t < 5000, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0, d0;
    wdata = '0; baud = 16'd4;
    wv0 = 0; wv1 = 0; wv2 = 0;
    brk0 = 0; brk1 = 0; brk2 = 0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txs", tx[0], 1);
    chk("rst_wready", wr[0], 0);
    chk("rst_level", lvl[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("wready_after_rst", wr[0], 1);
    mon_en = 1'b1;

    // 8N1 0xA5 and first-word latency
    wr0(8'hA5, 4, 1);
    chk("lat_txs_k", tx[0], 1);
    chk("lat_level_k", lvl[0], 1);
    @(posedge clk);
    #1;
    chk("lat_txs_k1", tx[0], 0);
    chk("lat_level_k1", lvl[0], 0);
    chk("lat_busy_k1", busy[0], 1);
    wait_idle(0);

    // even parity with two stops, odd parity
    @(negedge clk);
    wdata = 8'hA5;
    chk("par_wready1", wr[1], 1);
    chk("par_wready2", wr[2], 1);
    wv1 = 1'b1;
    wv2 = 1'b1;
    qpush(1, item_t'{1'b0, 8'hA5, 4, 2, 2});
    qpush(2, item_t'{1'b0, 8'hA5, 4, 1, 1});
    @(posedge clk);
    #1 wv1 = 1'b0;
    wv2 = 1'b0;
    wait_idle(1);
    wait_idle(2);

    // burst of six, FIFO fills, frames back to back
    baud = 16'd2;
    d0 = done_cnt;
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      wr0(8'h11 * (i + 1), 2, 1);
      if (i == 0) t0 = cyc;
      if (i == 4) begin
        chk("burst_level_full", lvl[0], 4);
        chk("burst_wready_full", wr[0], 0);
      end
    end
    wait_idle(0);
    chk("burst_done_count", done_cnt - d0, 6);
    chk("burst_span", last_done_cyc - t0, 120);

    // divisor change mid-frame
    baud = 16'd4;
    wr0(8'h3C, 4, 1);
    repeat (10) @(posedge clk);
    #1 baud = 16'd8;
    wr0(8'h5A, 8, 1);
    wait_idle(0);

    // break in IDLE with a word queued behind it
    @(negedge clk);
    baud = 16'd4;
    brk0 = 1'b1;
    qpush(0, item_t'{1'b1, 8'h00, 4, 0, 1});
    @(posedge clk);
    #1;
    wr0(8'h81, 4, 1);
    chk("brk_level", lvl[0], 1);
    @(posedge clk);
    #1 brk0 = 1'b0;
    wait_idle(0);

    // divisors 0 and 1 act as 2
    baud = 16'd0;
    wr0(8'h33, 2, 1);
    wait_idle(0);
    baud = 16'd1;
    wr0(8'hC6, 2, 1);
    wait_idle(0);

    // reset in the middle of DATA
    mon_en = 1'b0;
    baud = 16'd4;
    wr0(8'h00, 4, 0);
    wr0(8'h12, 4, 0);
    wr0(8'h34, 4, 0);
    repeat (8) @(negedge clk);
    chk("pre_rst_txs", tx[0], 0);
    chk("pre_rst_level", lvl[0], 2);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_txs", tx[0], 1);
    chk("midrst_level", lvl[0], 0);
    chk("midrst_wready", wr[0], 0);
    chk("midrst_busy", busy[0], 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_done", done[0], 0);
      chk("midrst_wready_hold", wr[0], 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("postrst_wready", wr[0], 1);
    repeat (12) begin
      @(negedge clk);
      chk("postrst_txs", tx[0], 1);
      chk("postrst_done", done[0], 0);
      chk("postrst_busy", busy[0], 0);
    end
    mon_en = 1'b1;

    repeat (4) @(negedge clk);
    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);
    chk("sb2_empty", sb2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
